// File: rtl/acc_event_extract.sv
// Groups contiguous ACC-flagged samples into 128-bit particle event records held in a FWFT FIFO.
// Record is visible two cycles after its terminating sample; a full FIFO drops the record and counts it.

module acc_event_fifo #(
   parameter int DEPTH = 16,
   parameter int WID   = 128
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           push_i,
   input  logic [WID-1:0] push_dat_i,
   input  logic           pop_i,
   output logic           push_ok_o,
   output logic           empty_o,
   output logic [WID-1:0] head_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic [WID-1:0] mem_q [DEPTH];
   logic           full;
   logic           do_pop;

   always_comb begin
      empty_o   = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop    = pop_i && !empty_o;
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      push_ok_o = push_i && (!full || do_pop);
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_ok_o};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
      head_o    = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
   end
endmodule

module acc_event_extract #(
   parameter int FIFO_DEPTH = 16,
   parameter int REC_WID    = 128
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               laser_start_i,
   input  logic               filter_vld_i,
   input  logic [15:0]        filter_data_i,
   input  logic [15:0]        filter_haze_i,
   input  logic               filter_acc_result_i,
   input  logic [15:0]        min_width_i,
   input  logic [15:0]        max_width_i,
   output logic               event_vld_o,
   input  logic               event_rdy_i,
   output logic [REC_WID-1:0] event_data_o,
   output logic [31:0]        event_cnt_o,
   output logic [15:0]        drop_cnt_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_CLOSE} state_t;

   state_t       state_q, state_d;
   logic [31:0]  pos_cnt_q, pos_cnt_d;
   logic [31:0]  start_q, start_d;
   logic [15:0]  width_q, width_d;
   logic [15:0]  peak_q, peak_d;
   logic [15:0]  haze_q, haze_d;
   logic [31:0]  sum_q, sum_d;
   logic         split_q, split_d;
   logic         stop_q, stop_d;
   logic [31:0]  event_cnt_q, event_cnt_d;
   logic [15:0]  drop_cnt_q, drop_cnt_d;

   logic               open_evt;
   logic [15:0]        width_inc;
   logic [32:0]        sum_ext;
   logic [31:0]        sum_inc;
   logic               push_req;
   logic               push_ok;
   logic               fifo_empty;
   logic [REC_WID-1:0] fifo_head;
   logic [REC_WID-1:0] rec_dat;

   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      width_d   = width_q;
      peak_d    = peak_q;
      haze_d    = haze_q;
      sum_d     = sum_q;
      split_d   = split_q;
      stop_d    = stop_q;
      pos_cnt_d = laser_start_i ? pos_cnt_q + {31'd0, filter_vld_i} : 32'd0;
      open_evt  = laser_start_i && filter_vld_i && filter_acc_result_i;
      width_inc = (width_q == 16'hFFFF) ? width_q : width_q + 16'd1;
      sum_ext   = {1'b0, sum_q} + {17'd0, filter_data_i};
      sum_inc   = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];

      case (state_q)
         ST_ACTIVE: begin
            if (!laser_start_i) begin
               stop_d  = 1'b1;
               split_d = 1'b0;
               state_d = ST_CLOSE;
            end else if (filter_vld_i && !filter_acc_result_i) begin
               stop_d  = 1'b0;
               split_d = 1'b0;
               state_d = ST_CLOSE;
            end else if (filter_vld_i) begin
               width_d = width_inc;
               sum_d   = sum_inc;
               if (filter_data_i > peak_q) begin
                  peak_d = filter_data_i;
                  haze_d = filter_haze_i;
               end
               if ((max_width_i != 16'd0) && (width_inc == max_width_i)) begin
                  split_d = 1'b1;
                  stop_d  = 1'b0;
                  state_d = ST_CLOSE;
               end
            end
         end
         ST_CLOSE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Opening is shared by IDLE and CLOSE so a run starting right after a close loses nothing.
      if ((state_q != ST_ACTIVE) && open_evt) begin
         start_d = pos_cnt_q;
         width_d = 16'd1;
         peak_d  = filter_data_i;
         haze_d  = filter_haze_i;
         sum_d   = {16'd0, filter_data_i};
         stop_d  = 1'b0;
         split_d = (max_width_i == 16'd1);
         state_d = (max_width_i == 16'd1) ? ST_CLOSE : ST_ACTIVE;
      end

      push_req    = (state_q == ST_CLOSE) && (width_q >= min_width_i);
      rec_dat     = {start_q, width_q, peak_q, haze_q, sum_q, 14'd0, split_q, stop_q};
      event_cnt_d = event_cnt_q + {31'd0, push_ok};
      drop_cnt_d  = (push_req && !push_ok && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1
                                                                      : drop_cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         pos_cnt_q   <= '0;
         start_q     <= '0;
         width_q     <= '0;
         peak_q      <= '0;
         haze_q      <= '0;
         sum_q       <= '0;
         split_q     <= 1'b0;
         stop_q      <= 1'b0;
         event_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pos_cnt_q   <= pos_cnt_d;
         start_q     <= start_d;
         width_q     <= width_d;
         peak_q      <= peak_d;
         haze_q      <= haze_d;
         sum_q       <= sum_d;
         split_q     <= split_d;
         stop_q      <= stop_d;
         event_cnt_q <= event_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   acc_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WID   (REC_WID)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push_req),
      .push_dat_i (rec_dat),
      .pop_i      (event_rdy_i),
      .push_ok_o  (push_ok),
      .empty_o    (fifo_empty),
      .head_o     (fifo_head)
   );

   assign event_vld_o  = !fifo_empty;
   assign event_data_o = fifo_empty ? '0 : fifo_head;
   assign event_cnt_o  = event_cnt_q;
   assign drop_cnt_o   = drop_cnt_q;
endmodule

// File: tb/tb_acc_event_extract.sv
// Directed bench for acc_event_extract: hand-computed records checked with immediate assertions.
module tb_acc_event_extract;
   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst, laser, vld, acc, rdy;
   logic [15:0]  data, haze, minw, maxw;
   logic         ev_vld;
   logic [127:0] ev_dat;
   logic [31:0]  ev_cnt;
   logic [15:0]  drop;
   int           n_chk = 0;
   int           n_pass = 0;

   always #5 clk = ~clk;

   acc_event_extract #(.FIFO_DEPTH(DEPTH), .REC_WID(128)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .laser_start_i       (laser),
      .filter_vld_i        (vld),
      .filter_data_i       (data),
      .filter_haze_i       (haze),
      .filter_acc_result_i (acc),
      .min_width_i         (minw),
      .max_width_i         (maxw),
      .event_vld_o         (ev_vld),
      .event_rdy_i         (rdy),
      .event_data_o        (ev_dat),
      .event_cnt_o         (ev_cnt),
      .drop_cnt_o          (drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic smp(input logic a, input logic [15:0] d, input logic [15:0] h);
      vld  = 1'b1;
      acc  = a;
      data = d;
      haze = h;
      tick();
      vld  = 1'b0;
      acc  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pop();
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      vld = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [127:0] rec(input logic [31:0] st, input logic [15:0] w,
                                        input logic [15:0] pk, input logic [15:0] hz,
                                        input logic [31:0] sm, input logic sp, input logic so);
      return {st, w, pk, hz, sm, 14'd0, sp, so};
   endfunction

   initial begin
      rst = 1'b1; laser = 1'b0; vld = 1'b0; acc = 1'b0; rdy = 1'b0;
      data = '0; haze = '0; minw = '0; maxw = '0;
      idle(2);
      chk("rst_vld",  128'(ev_vld), 128'(0));
      chk("rst_data", ev_dat, 128'(0));
      chk("rst_cnt",  128'(ev_cnt), 128'(0));
      chk("rst_drop", 128'(drop), 128'(0));
      rst = 1'b0;

      // Basic run at position 100, tie on peak keeps the earlier haze.
      laser = 1'b1;
      for (int i = 0; i < 100; i++) smp(1'b0, 16'(i), 16'd0);
      smp(1'b1, 16'd10, 16'd1);
      smp(1'b1, 16'd30, 16'd2);
      smp(1'b1, 16'd30, 16'd3);
      smp(1'b1, 16'd20, 16'd4);
      smp(1'b1, 16'd5,  16'd5);
      smp(1'b0, 16'd0,  16'd0);
      chk("t1_vld_close", 128'(ev_vld), 128'(0));
      tick();
      chk("t1_vld_lat", 128'(ev_vld), 128'(1));
      chk("t1_rec", ev_dat, rec(32'd100, 16'd5, 16'd30, 16'd2, 32'd95, 1'b0, 1'b0));
      chk("t1_cnt", 128'(ev_cnt), 128'(1));
      pop();
      chk("t1_vld_pop", 128'(ev_vld), 128'(0));

      // Minimum width filter.
      pulse_reset();
      chk("t2_cnt_rst", 128'(ev_cnt), 128'(0));
      minw = 16'd3;
      smp(1'b1, 16'd7, 16'd0);
      smp(1'b1, 16'd8, 16'd0);
      smp(1'b0, 16'd0, 16'd0);
      idle(2);
      smp(1'b1, 16'd1, 16'd8);
      smp(1'b1, 16'd2, 16'd9);
      smp(1'b1, 16'd3, 16'd10);
      smp(1'b1, 16'd4, 16'd11);
      smp(1'b0, 16'd0, 16'd0);
      idle(2);
      chk("t2_cnt", 128'(ev_cnt), 128'(1));
      chk("t2_rec", ev_dat, rec(32'd3, 16'd4, 16'd4, 16'd11, 32'd10, 1'b0, 1'b0));
      pop();
      chk("t2_vld_pop", 128'(ev_vld), 128'(0));
      minw = 16'd0;

      // Forced split at width 4.
      pulse_reset();
      maxw = 16'd4;
      for (int i = 0; i < 10; i++) smp(1'b1, 16'(i + 1), 16'(100 + i));
      smp(1'b0, 16'd0, 16'd0);
      idle(2);
      chk("t3_cnt", 128'(ev_cnt), 128'(3));
      chk("t3_rec0", ev_dat, rec(32'd0, 16'd4, 16'd4, 16'd103, 32'd10, 1'b1, 1'b0));
      pop();
      chk("t3_rec1", ev_dat, rec(32'd4, 16'd4, 16'd8, 16'd107, 32'd26, 1'b1, 1'b0));
      pop();
      chk("t3_rec2", ev_dat, rec(32'd8, 16'd2, 16'd10, 16'd109, 32'd19, 1'b0, 1'b0));
      pop();
      chk("t3_vld_pop", 128'(ev_vld), 128'(0));
      maxw = 16'd0;

      // Laser drop mid-run; the next scan restarts at position 0.
      pulse_reset();
      smp(1'b1, 16'd5, 16'd1);
      smp(1'b1, 16'd6, 16'd2);
      smp(1'b1, 16'd7, 16'd3);
      laser = 1'b0;
      smp(1'b1, 16'd99, 16'd9);
      tick();
      chk("t4_vld", 128'(ev_vld), 128'(1));
      chk("t4_rec_stop", ev_dat, rec(32'd0, 16'd3, 16'd7, 16'd3, 32'd18, 1'b0, 1'b1));
      pop();
      laser = 1'b1;
      smp(1'b1, 16'd50, 16'd60);
      smp(1'b0, 16'd0, 16'd0);
      idle(2);
      chk("t4_rec_restart", ev_dat, rec(32'd0, 16'd1, 16'd50, 16'd60, 32'd50, 1'b0, 1'b0));
      pop();

      // Overflow under backpressure, then ordered drain.
      pulse_reset();
      for (int k = 0; k < DEPTH + 2; k++) begin
         smp(1'b1, 16'(k + 1), 16'(k));
         smp(1'b0, 16'd0, 16'd0);
      end
      idle(2);
      chk("t5_drop", 128'(drop), 128'(2));
      chk("t5_cnt", 128'(ev_cnt), 128'(DEPTH));
      chk("t5_head", ev_dat, rec(32'd0, 16'd1, 16'd1, 16'd0, 32'd1, 1'b0, 1'b0));
      idle(3);
      chk("t5_head_stable", ev_dat, rec(32'd0, 16'd1, 16'd1, 16'd0, 32'd1, 1'b0, 1'b0));
      for (int k = 0; k < DEPTH; k++) begin
         chk("t5_drain_vld", 128'(ev_vld), 128'(1));
         chk("t5_drain_rec", ev_dat,
             rec(32'(2 * k), 16'd1, 16'(k + 1), 16'(k), 32'(k + 1), 1'b0, 1'b0));
         pop();
      end
      chk("t5_empty", 128'(ev_vld), 128'(0));

      // New run opening during CLOSE, then reset in the middle of an event.
      pulse_reset();
      smp(1'b1, 16'd3, 16'd20);
      smp(1'b1, 16'd4, 16'd21);
      smp(1'b0, 16'd0, 16'd0);
      smp(1'b1, 16'd9, 16'd30);
      smp(1'b1, 16'd2, 16'd31);
      smp(1'b0, 16'd0, 16'd0);
      idle(2);
      chk("t6_cnt", 128'(ev_cnt), 128'(2));
      chk("t6_recA", ev_dat, rec(32'd0, 16'd2, 16'd4, 16'd21, 32'd7, 1'b0, 1'b0));
      pop();
      chk("t6_recB", ev_dat, rec(32'd3, 16'd2, 16'd9, 16'd30, 32'd11, 1'b0, 1'b0));
      smp(1'b1, 16'd40, 16'd0);
      smp(1'b1, 16'd41, 16'd0);
      rst = 1'b1;
      vld = 1'b0;
      tick();
      chk("t6_rst_vld",  128'(ev_vld), 128'(0));
      chk("t6_rst_cnt",  128'(ev_cnt), 128'(0));
      chk("t6_rst_drop", 128'(drop), 128'(0));
      chk("t6_rst_data", ev_dat, 128'(0));
      rst = 1'b0;
      smp(1'b0, 16'd0, 16'd0);
      idle(2);
      chk("t6_discard_vld", 128'(ev_vld), 128'(0));
      chk("t6_discard_cnt", 128'(ev_cnt), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
